// File: rtl/counter_seq_pkg.sv
// Shared constants and helpers for the counter-increment sequencer.
// Requester indices double as priorities: index 0 is served first.
package counter_seq_pkg;

   localparam int DEF_NREQ      = 8;
   localparam int DEF_CYCLE_LEN = 12;
   localparam int DEF_TPW       = 4;

   localparam int REQ_TIME1 = 0;
   localparam int REQ_TIME3 = 1;
   localparam int REQ_F02A  = 2;
   localparam int REQ_F02B  = 3;
   localparam int REQ_FS02  = 4;
   localparam int REQ_TIME2 = 5;
   localparam int REQ_TIME4 = 6;
   localparam int REQ_TIME5 = 7;

   typedef logic [DEF_NREQ-1:0] req_vec_t;

   // Isolates the lowest set bit (two's-complement trick): lowest index wins.
   function automatic req_vec_t prio_onehot(input req_vec_t v);
      return v & (~v + req_vec_t'(1));
   endfunction

endpackage

// File: rtl/counter_priority_sequencer_tp_generator.sv
// Memory-cycle time-pulse counter: tp runs 1..CYCLE_LEN and wraps to 1.
// cycle_end flags the last pulse, whose closing edge is the decision edge.
module tp_generator
   import counter_seq_pkg::*;
#(
   parameter int CYCLE_LEN = DEF_CYCLE_LEN,
   parameter int TPW       = DEF_TPW
) (
   input  logic           clk,
   input  logic           rst,
   output logic [TPW-1:0] tp,
   output logic           cycle_start,
   output logic           cycle_end
);

   localparam logic [TPW-1:0] TP_FIRST = TPW'(1);
   localparam logic [TPW-1:0] TP_LAST  = TPW'(CYCLE_LEN);

   always_ff @(posedge clk) begin
      if (rst) begin
         tp <= TP_FIRST;
      end else if (tp == TP_LAST) begin
         tp <= TP_FIRST;
      end else begin
         tp <= tp + TPW'(1);
      end
   end

   assign cycle_start = (tp == TP_FIRST);
   assign cycle_end   = (tp == TP_LAST);

endmodule

// File: rtl/counter_priority_sequencer.sv
// Latches single-cycle counter increment requests and grants one per memory
// cycle in fixed priority; the grant is held for the whole T01..Tn frame.
module counter_priority_sequencer
   import counter_seq_pkg::*;
#(
   parameter int NREQ      = DEF_NREQ,
   parameter int CYCLE_LEN = DEF_CYCLE_LEN,
   parameter int TPW       = DEF_TPW
) (
   input  logic            FS01_,
   input  logic            rst,
   input  logic [NREQ-1:0] req_pulse,
   input  logic            inhint,
   input  logic            clear_lost,
   output logic [TPW-1:0]  tp,
   output logic            cycle_start,
   output logic [NREQ-1:0] cnt_grant,
   output logic            cnt_active,
   output logic [NREQ-1:0] pending,
   output logic [NREQ-1:0] lost
);

   logic            decision;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] win_oh;
   logic [NREQ-1:0] pending_d;
   logic [NREQ-1:0] lost_set;
   logic [NREQ-1:0] lost_d;

   tp_generator #(
      .CYCLE_LEN (CYCLE_LEN),
      .TPW       (TPW)
   ) u_tp (
      .clk         (FS01_),
      .rst         (rst),
      .tp          (tp),
      .cycle_start (cycle_start),
      .cycle_end   (decision)
   );

   // A pulse landing on an already-pending winner is a fresh request, so it
   // stays pending rather than being consumed by the grant or marked lost.
   always_comb begin
      eligible = pending | req_pulse;
      win_oh   = '0;
      if (decision && !inhint) begin
         win_oh = prio_onehot(eligible);
      end
      pending_d = eligible & ~(win_oh & ~(pending & req_pulse));
      lost_set  = req_pulse & pending & ~win_oh;
      lost_d    = clear_lost ? lost_set : (lost | lost_set);
   end

   always_ff @(posedge FS01_) begin
      if (rst) begin
         cnt_grant  <= '0;
         cnt_active <= 1'b0;
         pending    <= '0;
         lost       <= '0;
      end else begin
         pending <= pending_d;
         lost    <= lost_d;
         if (decision) begin
            cnt_grant  <= win_oh;
            cnt_active <= |win_oh;
         end
      end
   end

endmodule

// File: tb/tb_counter_priority_sequencer.sv
// Directed bench for counter_priority_sequencer: hand-computed grants,
// pending/lost flags and time-pulse sequence over a series of scenarios.
module tb_counter_priority_sequencer;

   localparam int NREQ      = 8;
   localparam int CYCLE_LEN = 12;
   localparam int TPW       = 4;

   logic            FS01_ = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req_pulse;
   logic            inhint;
   logic            clear_lost;
   logic [TPW-1:0]  tp;
   logic            cycle_start;
   logic [NREQ-1:0] cnt_grant;
   logic            cnt_active;
   logic [NREQ-1:0] pending;
   logic [NREQ-1:0] lost;

   int checks   = 0;
   int failures = 0;

   always #5 FS01_ = ~FS01_;

   counter_priority_sequencer #(
      .NREQ      (NREQ),
      .CYCLE_LEN (CYCLE_LEN),
      .TPW       (TPW)
   ) dut (
      .FS01_       (FS01_),
      .rst         (rst),
      .req_pulse   (req_pulse),
      .inhint      (inhint),
      .clear_lost  (clear_lost),
      .tp          (tp),
      .cycle_start (cycle_start),
      .cnt_grant   (cnt_grant),
      .cnt_active  (cnt_active),
      .pending     (pending),
      .lost        (lost)
   );

   task automatic tick();
      @(posedge FS01_);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tp(input int k);
      int n;
      n = 0;
      while (tp !== TPW'(k) && n < 2 * CYCLE_LEN + 2) begin
         tick();
         n++;
      end
      if (tp !== TPW'(k)) begin
         checks++;
         failures++;
         $display("FAIL wait_tp observed=%0h expected=%0h", tp, k);
      end
   endtask

   initial begin
      int exp_tp;
      rst        = 1'b1;
      req_pulse  = '0;
      inhint     = 1'b0;
      clear_lost = 1'b0;

      // Reset held for three clocks
      tick(); tick(); tick();
      chk("rst_tp", 32'(tp), 32'd1);
      chk("rst_cycle_start", 32'(cycle_start), 32'd1);
      chk("rst_grant", 32'(cnt_grant), 32'h0);
      chk("rst_active", 32'(cnt_active), 32'd0);
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_lost", 32'(lost), 32'h0);

      // Idle: tp walks 1..12 twice, nothing granted
      rst = 1'b0;
      exp_tp = 1;
      for (int i = 0; i < 2 * CYCLE_LEN; i++) begin
         tick();
         exp_tp = (exp_tp % CYCLE_LEN) + 1;
         chk("idle_tp", 32'(tp), 32'(exp_tp));
         chk("idle_cycle_start", 32'(cycle_start), 32'(exp_tp == 1));
         chk("idle_grant", 32'(cnt_grant), 32'h0);
      end
      chk("idle_pending", 32'(pending), 32'h0);
      chk("idle_lost", 32'(lost), 32'h0);

      // Single request at tp=5
      wait_tp(5);
      req_pulse = 8'h04;
      tick();
      req_pulse = '0;
      chk("single_pending", 32'(pending), 32'h04);
      chk("single_no_early_grant", 32'(cnt_grant), 32'h0);
      wait_tp(12);
      chk("single_pre_decision", 32'(cnt_grant), 32'h0);
      tick();
      chk("single_tp1", 32'(tp), 32'd1);
      chk("single_grant", 32'(cnt_grant), 32'h04);
      chk("single_active", 32'(cnt_active), 32'd1);
      chk("single_pending_clr", 32'(pending), 32'h0);
      for (int i = 2; i <= CYCLE_LEN; i++) begin
         tick();
         chk("single_grant_hold", 32'(cnt_grant), 32'h04);
      end
      tick();
      chk("single_grant_end", 32'(cnt_grant), 32'h0);
      chk("single_active_end", 32'(cnt_active), 32'd0);

      // Two requests together: lower index first, then the other
      wait_tp(3);
      req_pulse = 8'h0A;
      tick();
      req_pulse = '0;
      chk("simul_pending", 32'(pending), 32'h0A);
      wait_tp(1);
      chk("simul_grant1", 32'(cnt_grant), 32'h02);
      chk("simul_pending1", 32'(pending), 32'h08);
      wait_tp(12);
      tick();
      chk("simul_grant2", 32'(cnt_grant), 32'h08);
      chk("simul_pending2", 32'(pending), 32'h0);
      wait_tp(12);
      tick();
      chk("simul_grant3", 32'(cnt_grant), 32'h0);

      // Lost pulse, then clear_lost
      wait_tp(2);
      req_pulse = 8'h40;
      tick();
      req_pulse = '0;
      chk("lost_first_pending", 32'(pending), 32'h40);
      chk("lost_first_none", 32'(lost), 32'h0);
      wait_tp(7);
      req_pulse = 8'h40;
      tick();
      req_pulse = '0;
      chk("lost_set", 32'(lost), 32'h40);
      chk("lost_pending", 32'(pending), 32'h40);
      wait_tp(9);
      clear_lost = 1'b1;
      tick();
      clear_lost = 1'b0;
      chk("lost_cleared", 32'(lost), 32'h0);
      wait_tp(12);
      tick();
      chk("lost_grant", 32'(cnt_grant), 32'h40);
      chk("lost_pending_clr", 32'(pending), 32'h0);
      wait_tp(12);
      tick();
      chk("lost_single_grant", 32'(cnt_grant), 32'h0);

      // Collision at the decision edge on the winner
      wait_tp(3);
      req_pulse = 8'h01;
      tick();
      req_pulse = '0;
      wait_tp(12);
      req_pulse = 8'h01;
      tick();
      req_pulse = '0;
      chk("coll_grant", 32'(cnt_grant), 32'h01);
      chk("coll_pending_kept", 32'(pending), 32'h01);
      chk("coll_not_lost", 32'(lost), 32'h0);
      wait_tp(12);
      tick();
      chk("coll_grant_again", 32'(cnt_grant), 32'h01);
      chk("coll_pending_clr", 32'(pending), 32'h0);
      wait_tp(12);
      tick();
      chk("coll_grant_end", 32'(cnt_grant), 32'h0);

      // New loss and clear_lost in the same cycle: set wins
      wait_tp(2);
      req_pulse = 8'h10;
      tick();
      req_pulse = '0;
      wait_tp(4);
      req_pulse  = 8'h10;
      clear_lost = 1'b1;
      tick();
      req_pulse  = '0;
      clear_lost = 1'b0;
      chk("setwins_lost", 32'(lost), 32'h10);
      clear_lost = 1'b1;
      tick();
      clear_lost = 1'b0;
      chk("setwins_cleared", 32'(lost), 32'h0);
      wait_tp(12);
      tick();
      chk("setwins_grant", 32'(cnt_grant), 32'h10);
      wait_tp(12);
      tick();
      chk("setwins_grant_end", 32'(cnt_grant), 32'h0);

      // Inhibit at the decision edge defers the grant one cycle
      wait_tp(3);
      req_pulse = 8'h20;
      tick();
      req_pulse = '0;
      wait_tp(12);
      inhint = 1'b1;
      tick();
      inhint = 1'b0;
      chk("inh_grant", 32'(cnt_grant), 32'h0);
      chk("inh_active", 32'(cnt_active), 32'd0);
      chk("inh_pending", 32'(pending), 32'h20);
      wait_tp(6);
      inhint = 1'b1;
      tick();
      inhint = 1'b0;
      wait_tp(12);
      tick();
      chk("inh_later_grant", 32'(cnt_grant), 32'h20);
      chk("inh_later_pending", 32'(pending), 32'h0);

      // Reset at tp=6 in the middle of a grant, with pending and lost set
      wait_tp(3);
      req_pulse = 8'h02;
      tick();
      req_pulse = 8'h02;
      tick();
      req_pulse = '0;
      chk("mid_lost", 32'(lost), 32'h02);
      chk("mid_pending", 32'(pending), 32'h02);
      chk("mid_tp", 32'(tp), 32'd5);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_tp", 32'(tp), 32'd1);
      chk("mid_rst_cycle_start", 32'(cycle_start), 32'd1);
      chk("mid_rst_grant", 32'(cnt_grant), 32'h0);
      chk("mid_rst_active", 32'(cnt_active), 32'd0);
      chk("mid_rst_pending", 32'(pending), 32'h0);
      chk("mid_rst_lost", 32'(lost), 32'h0);

      // First decision edge comes CYCLE_LEN clocks after release; a pulse at
      // tp=12 on the lowest-priority line is granted on the very next clock
      for (int i = 0; i < CYCLE_LEN - 1; i++) tick();
      chk("post_rst_tp12", 32'(tp), 32'd12);
      chk("post_rst_grant_pre", 32'(cnt_grant), 32'h0);
      req_pulse = 8'h80;
      tick();
      req_pulse = '0;
      chk("late_grant", 32'(cnt_grant), 32'h80);
      chk("late_pending", 32'(pending), 32'h0);
      chk("late_active", 32'(cnt_active), 32'd1);
      wait_tp(12);
      tick();
      chk("late_grant_end", 32'(cnt_grant), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
